// File: rtl/uart_control_tx.sv
// Control-frame UART sender: 6-byte checksummed frame (HDR0 HDR1 hi lo CHK TRAILER), 8N1, LSB first.
// Bit time is 16 ticks of a bps_div clock divider; tx/busy/done are registered.
module uart_control_tx #(
  parameter int         GAP_BITS = 0,
  parameter logic [7:0] HDR0     = 8'hA5,
  parameter logic [7:0] HDR1     = 8'h5A,
  parameter logic [7:0] TRAILER  = 8'h0D
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] control,
  input  logic [15:0] bps_div,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_GAP, S_DONE} state_t;

  localparam logic [3:0] GAP_LAST = (GAP_BITS > 0) ? 4'(GAP_BITS - 1) : 4'd0;

  state_t      state, state_nx;
  logic [15:0] ctrl_q, div_q, div_cnt;
  logic [7:0]  chk_q, chk_in, shift, shift_nx, cur_byte;
  logic [3:0]  tick_cnt, gap_cnt;
  logic [2:0]  bit_cnt, byte_idx;
  logic        tick, bit_end, accept;
  logic        tx_d, busy_d, done_d;

  assign accept  = (state == S_IDLE) && start;
  assign tick    = (div_cnt == div_q - 16'd1);
  assign bit_end = tick && (tick_cnt == 4'hF);
  // Makes the 8-bit sum of bytes 0..4 come out to zero.
  assign chk_in  = 8'h00 - (HDR0 + HDR1 + control[15:8] + control[7:0]);

  always_comb begin
    case (byte_idx)
      3'd0:    cur_byte = HDR0;
      3'd1:    cur_byte = HDR1;
      3'd2:    cur_byte = ctrl_q[15:8];
      3'd3:    cur_byte = ctrl_q[7:0];
      3'd4:    cur_byte = chk_q;
      default: cur_byte = TRAILER;
    endcase
  end

  always_comb begin
    shift_nx = shift;
    if (state == S_START && bit_end)     shift_nx = cur_byte;
    else if (state == S_DATA && bit_end) shift_nx = {1'b0, shift[7:1]};
  end

  // State register plus datapath counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      shift    <= '0;
      ctrl_q   <= '0;
      div_q    <= 16'd1;
      chk_q    <= '0;
      div_cnt  <= '0;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      gap_cnt  <= '0;
      byte_idx <= '0;
    end else begin
      state <= state_nx;
      tx    <= tx_d;
      busy  <= busy_d;
      done  <= done_d;
      shift <= shift_nx;
      if (accept) begin
        ctrl_q   <= control;
        div_q    <= (bps_div == 16'd0) ? 16'd1 : bps_div;
        chk_q    <= chk_in;
        div_cnt  <= '0;
        tick_cnt <= '0;
        bit_cnt  <= '0;
        gap_cnt  <= '0;
        byte_idx <= '0;
      end else if (state != S_IDLE && state != S_DONE) begin
        div_cnt <= tick ? 16'd0 : div_cnt + 16'd1;
        if (tick) tick_cnt <= tick_cnt + 4'd1;
        if (bit_end) begin
          case (state)
            S_DATA: bit_cnt <= bit_cnt + 3'd1;
            S_STOP: begin
              gap_cnt <= '0;
              if (byte_idx != 3'd5) byte_idx <= byte_idx + 3'd1;
            end
            S_GAP:   gap_cnt <= gap_cnt + 4'd1;
            default: ;
          endcase
        end
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_START;
      S_START: if (bit_end) state_nx = S_DATA;
      S_DATA:  if (bit_end && bit_cnt == 3'd7) state_nx = S_STOP;
      S_STOP: begin
        if (bit_end) begin
          if (byte_idx == 3'd5)  state_nx = S_DONE;
          else if (GAP_BITS > 0) state_nx = S_GAP;
          else                   state_nx = S_START;
        end
      end
      S_GAP:   if (bit_end && gap_cnt == GAP_LAST) state_nx = S_START;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered tx lines up with it.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_nx)
      S_START: begin tx_d = 1'b0;        busy_d = 1'b1; end
      S_DATA:  begin tx_d = shift_nx[0]; busy_d = 1'b1; end
      S_STOP,
      S_GAP:   busy_d = 1'b1;
      S_DONE:  done_d = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_uart_control_tx.sv
// Bench for uart_control_tx: two instances (GAP_BITS 0 and 2) checked against a bit-level frame model.
module tb_uart_control_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        st[2];
  logic [15:0] ctl[2];
  logic [15:0] bps[2];
  logic        txo[2], bsy[2], dn[2];
  int          n_chk = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  uart_control_tx #(.GAP_BITS(0)) u_dut0 (
    .clock(clk), .reset(rst), .start(st[0]), .control(ctl[0]), .bps_div(bps[0]),
    .tx(txo[0]), .busy(bsy[0]), .done(dn[0]));

  uart_control_tx #(.GAP_BITS(2)) u_dut2 (
    .clock(clk), .reset(rst), .start(st[1]), .control(ctl[1]), .bps_div(bps[1]),
    .tx(txo[1]), .busy(bsy[1]), .done(dn[1]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle_window(input int k, input int n, input string tag);
    int bad = 0;
    repeat (n) begin
      if (txo[k] !== 1'b1 || bsy[k] !== 1'b0 || dn[k] !== 1'b0) bad++;
      @(negedge clk);
    end
    check(tag, bad, 0);
  endtask

  // Send one frame and check it; div_late is applied one cycle after start,
  // mid_start (>=0) pulses start with a different control word at that cycle.
  task automatic frame(input int k, input logic [15:0] ctrl, input logic [15:0] div,
                       input logic [15:0] div_late, input int mid_start);
    int gap, t, len, sum, dsum, busy_n, done_n, glitch, base;
    logic [7:0] eb[6];
    logic [7:0] got;
    logic bits[$];
    logic wave[$];
    logic bw[$];
    logic dw[$];
    gap  = (k == 0) ? 0 : 2;
    t    = 16 * ((div == 16'd0) ? 1 : int'(div));
    sum  = 'hA5 + 'h5A + int'(ctrl[15:8]) + int'(ctrl[7:0]);
    eb   = '{8'hA5, 8'h5A, ctrl[15:8], ctrl[7:0], 8'((256 - sum % 256) % 256), 8'h0D};
    for (int i = 0; i < 6; i++) begin
      bits.push_back(1'b0);
      for (int j = 0; j < 8; j++) bits.push_back(eb[i][j]);
      bits.push_back(1'b1);
      if (i < 5) repeat (gap) bits.push_back(1'b1);
    end
    len = bits.size() * t;

    @(negedge clk);
    ctl[k] = ctrl; bps[k] = div; st[k] = 1'b1;
    @(negedge clk);
    st[k] = 1'b0; bps[k] = div_late;
    for (int c = 0; c <= len; c++) begin
      wave.push_back(txo[k]); bw.push_back(bsy[k]); dw.push_back(dn[k]);
      if (c == mid_start) begin st[k] = 1'b1; ctl[k] = ~ctrl; end
      else st[k] = 1'b0;
      @(negedge clk);
    end

    dsum = 0;
    for (int i = 0; i < 6; i++) begin
      base = i * (10 + gap);
      check($sformatf("k%0d_b%0d_start", k, i), wave[base*t + t/2], 1'b0);
      for (int j = 0; j < 8; j++) got[j] = wave[(base+1+j)*t + t/2];
      check($sformatf("k%0d_b%0d_data", k, i), got, eb[i]);
      check($sformatf("k%0d_b%0d_stop", k, i), wave[(base+9)*t + t/2], 1'b1);
      if (i < 5) dsum += int'(got);
    end
    check("chk_sum_zero", dsum % 256, 0);

    glitch = 0; busy_n = 0; done_n = 0;
    for (int c = 0; c < len; c++) begin
      if (wave[c] !== bits[c / t]) glitch++;
      if (bw[c] === 1'b1) busy_n++;
      if (dw[c] !== 1'b0) done_n++;
    end
    check("bit_timing", glitch, 0);
    check("busy_high", busy_n, len);
    check("done_early", done_n, 0);
    check("done_at_L", dw[len], 1'b1);
    check("busy_at_L", bw[len], 1'b0);
    idle_window(k, 40, "idle_after");
  endtask

  // Reset in S_DATA of byte 3 abandons the frame.
  task automatic abort_frame(input int k, input logic [15:0] ctrl, input logic [15:0] div);
    int gap, t, cut;
    gap = (k == 0) ? 0 : 2;
    t   = 16 * ((div == 16'd0) ? 1 : int'(div));
    cut = (3 * (10 + gap) + 3) * t + t / 2;
    @(negedge clk);
    ctl[k] = ctrl; bps[k] = div; st[k] = 1'b1;
    @(negedge clk);
    st[k] = 1'b0;
    for (int c = 0; c < cut; c++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_tx", txo[k], 1'b1);
    check("rst_busy", bsy[k], 1'b0);
    check("rst_done", dn[k], 1'b0);
    rst = 1'b0;
    idle_window(k, 100, "rst_quiet");
  endtask

  initial begin
    rst = 1'b1;
    st  = '{1'b0, 1'b0};
    ctl = '{16'h0, 16'h0};
    bps = '{16'd1, 16'd1};
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("reset_tx", txo[k], 1'b1);
      check("reset_busy", bsy[k], 1'b0);
      check("reset_done", dn[k], 1'b0);
    end
    rst = 1'b0;
    @(negedge clk);

    frame(0, 16'h0236, 16'd2, 16'd2, -1);
    frame(0, 16'hFFFF, 16'd1, 16'd1, -1);
    frame(0, 16'h0000, 16'd1, 16'd1, -1);
    frame(1, 16'h1234, 16'd0, 16'd0, -1);
    frame(0, 16'hBEEF, 16'd1, 16'd1, (2 * 10 + 4) * 16);
    frame(1, 16'h7E81, 16'd1, 16'd1, (2 * 12 + 4) * 16);
    frame(0, 16'h4C21, 16'd2, 16'd5, -1);
    frame(0, 16'h4C21, 16'd5, 16'd5, -1);
    abort_frame(0, 16'h5A3C, 16'd1);
    frame(0, 16'h5A3C, 16'd1, 16'd1, -1);
    abort_frame(1, 16'hC3A5, 16'd1);
    frame(1, 16'hC3A5, 16'd1, 16'd1, -1);

    repeat (5) begin
      int          k;
      logic [15:0] c;
      logic [15:0] d;
      k = int'($urandom_range(0, 1));
      c = 16'($urandom);
      d = 16'($urandom_range(0, 3));
      frame(k, c, d, d, -1);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
